// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a valid/ready payload handshake.
//
// Frame: start bit (0), DATAWIDTH data bits LSB first, optional parity bit,
// STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT clocks.
//
// Ports:
//   clk        system clock, rising edge
//   i_reset    synchronous active-high reset; aborts any frame in progress
//   i_data     payload, captured only on the i_valid && o_ready edge
//   i_valid    payload available
//   o_ready    high in IDLE only
//   o_tx_data  serial line, idle high (registered)
//   o_busy     high while a frame is on the line
//   o_done     one-cycle pulse on the first IDLE cycle after a frame
module uart_tx_param #(
  parameter int DATAWIDTH    = 8,
  parameter int CLKS_PER_BIT = 10416,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic [DATAWIDTH-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic                 o_tx_data,
  output logic                 o_busy,
  output logic                 o_done
);

  if (DATAWIDTH < 5 || DATAWIDTH > 9) begin : g_bad_dw
    $error("uart_tx_param: DATAWIDTH must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_par
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATAWIDTH + 1);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE = BW'(1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATAWIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic [CW-1:0] BIT_ONE = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [DATAWIDTH-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 tick;

  assign tick = (baud_q == BAUD_MAX);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      baud_d = tick ? '0 : baud_q + BAUD_ONE;
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          state_d = S_START;
          shift_d = i_data;
          // Parity is fixed at capture so later i_data changes cannot leak in.
          par_d   = (PARITY == 1) ? ~^i_data : ^i_data;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + BIT_ONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the state being entered, so the pin is a clean flop.
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign o_ready   = (state_q == S_IDLE);
  assign o_busy    = (state_q != S_IDLE);
  assign o_tx_data = tx_q;
  assign o_done    = done_q;

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter. It is the next generation of the single-format 8N1 transmitter.
- Configurable data width, parity mode, stop-bit count and bit period.
- A valid/ready handshake replaces the level-held transmit strobe, so frames can be queued back-to-back with no lost or repeated bytes.
- Sits between the SoC bus-side UART register block and the TX pin.

Parameters:
DATAWIDTH, 8, payload bits per frame; legal 5..9
CLKS_PER_BIT, 10416, clk cycles per serial bit (100 MHz / 9600 baud); legal >= 2
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits; legal 1 or 2

Ports:
clk  input  1  system clock; all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_data  input  DATAWIDTH  payload; sampled only on handshake
i_valid  input  1  payload available
o_ready  output  1  transmitter can accept a payload
o_tx_data  output  1  serial line; idle high
o_busy  output  1  high while a frame is on the line
o_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Reset (i_reset=1 at a rising edge) has priority over everything.
  - Next-cycle values: o_tx_data=1, o_ready=1, o_busy=0, o_done=0.
  - State goes to IDLE; bit counter and baud counter clear.
  - Reset mid-frame aborts the frame immediately; the line returns high with no partial stop bit.
- States: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
- Handshake:
  - Transfer occurs when i_valid=1 and o_ready=1 at a rising edge.
  - o_ready=1 only in IDLE.
  - i_data is latched into a shift register at the transfer edge; later changes on i_data have no effect on the frame.
  - i_valid is ignored while o_ready=0.
- Latency: o_tx_data goes low and o_busy goes high on the cycle after the transfer edge.
- Bit timing:
  - Every bit is held for exactly CLKS_PER_BIT cycles.
  - The baud counter runs 0..CLKS_PER_BIT-1; a state/bit advance happens when it reaches CLKS_PER_BIT-1, then it wraps to 0.
- Frame order:
  - 1 start bit (0).
  - DATAWIDTH data bits, LSB first.
  - Parity bit: odd = ~^data, even = ^data, computed on the latched data.
  - STOP_BITS stop bits (1).
- Frame length: F = (1 + DATAWIDTH + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles of o_busy=1.
- End of frame:
  - On the edge that ends the last stop bit, the next-cycle values are: state IDLE, o_done=1 for exactly one cycle, o_busy=0, o_ready=1, o_tx_data=1.
- Back-to-back: if i_valid is held high, the next transfer happens on the first IDLE cycle. The line therefore idles high for exactly 1 cycle between frames, and no frame is skipped or duplicated.
- Width rules:
  - Baud counter width is $clog2(CLKS_PER_BIT).
  - Bit counter width is $clog2(DATAWIDTH+1).
  - No arithmetic overflow is permitted at the parameter extremes (DATAWIDTH=9, CLKS_PER_BIT=2).
- Illegal parameter values are rejected at elaboration with $error.

Test Plan:
1. Default 8N1, CLKS_PER_BIT=4, send 8'b0011_0011 -> line low 4 cycles, then bits 1,1,0,0,1,1,0,0 at 4 cycles each, then high 4 cycles; o_busy=1 for 40 cycles; o_done pulses once.
2. PARITY=2, STOP_BITS=2, CLKS_PER_BIT=4, send 8'b1010_1010 -> parity bit 0 and two stop bits; o_busy=1 for 48 cycles. Repeat with PARITY=1 -> parity bit 1.
3. Back-to-back: i_valid held high, send 8'hAA then 8'h0F -> two complete frames with 1 idle-high cycle between; 2 o_done pulses; decoded bytes AA, 0F.
4. Change i_data every cycle during a frame -> transmitted bits match the value latched at transfer; o_ready=0 throughout the frame.
5. Reset asserted in the middle of a data bit -> the next cycle has o_tx_data=1, o_busy=0, o_ready=1, o_done=0; a new frame sent afterwards is clean.
6. DATAWIDTH=5, CLKS_PER_BIT=2, PARITY=1, send 5'b10110 -> frame 1+5+1+1 bits = 16 cycles; parity bit 0 (odd parity, three 1s); bits LSB first: 0,1,1,0,1.
